rv_exec_stage: RTL and testbench
================================

// Module: rv_exec_stage
// PURPOSE
//  Execute/writeback stage directly downstream of the R-type instruction decoder.
//  Consumes the registered rs1/rs2/rd addresses and the one-hot operation enables.
//  Holds the 32-entry integer register file and performs the selected RV64 R-type ALU op.
//  Registers the result, then writes it back to rd the following cycle.
//  Forwards the in-flight result to a dependent instruction issued immediately after it.
// PARAMETERS
//  XLEN  64  datapath width; only 32 or 64 allowed; at 32, subw_en/sraw_en count as illegal
// PORTS
//  clk         in   1     rising-edge clock, single clock domain
//  rst_n       in   1     synchronous reset, active low
//  in_valid    in   1     decoder outputs below are a valid instruction this cycle
//  rs1_addr    in   5     source register 1 index
//  rs2_addr    in   5     source register 2 index
//  rd_addr     in   5     destination register index
//  add_en,sub_en,sll_en,slt_en,sltu_en,xor_en,srl_en,sra_en,or_en,and_en,subw_en,sraw_en
//              in   1 ea  one-hot operation select from the decoder
//  ld_en       in   1     loader write strobe (register-file initialisation)
//  ld_addr     in   5     loader write index
//  ld_data     in   XLEN  loader write data
//  out_valid   out  1     execute-stage result register holds an instruction
//  out_rd      out  5     rd of that instruction
//  out_result  out  XLEN  ALU result (0 when illegal)
//  illegal     out  1     that instruction had zero or more than one enable asserted
//  dbg_addr    in   5     debug read index
//  dbg_data    out  XLEN  combinational read of architectural register file; x0 reads 0
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge)
//   - out_valid=0, out_rd=0, out_result=0, illegal=0.
//   - All 32 registers are cleared to 0.
//   - A pending execute-stage result is discarded and never written back.
//  Pipeline
//   - Cycle N, in_valid=1: read operands a=rs1, b=rs2; compute result combinationally.
//   - At edge ending cycle N: out_valid=1, out_rd=rd_addr, out_result=result, illegal=flag.
//   - When in_valid=0, out_valid=0 at the next edge and the other outputs hold.
//   - Latency from in_valid to out_valid is 1 cycle.
//   - At edge ending cycle N+1: regfile[out_rd] <= out_result when out_valid=1, !illegal and out_rd!=0.
//   - Throughput: one instruction per cycle; no stalls; no backpressure.
//  Operand read and forwarding
//   - Forwarding: if out_valid && !illegal && out_rd!=0 && rsX==out_rd, operand X = out_result.
//   - Otherwise operand X = regfile[rsX]; x0 always reads 0.
//  Arithmetic (XLEN bits, wrap-around, no overflow flag)
//   - add a+b; sub a-b; xor/or/and bitwise.
//   - sll/srl/sra shift by b[log2(XLEN)-1:0]; sra is arithmetic.
//   - slt signed / sltu unsigned compare; result 1 or 0, zero-extended.
//   - subw: sign-extend bit 31 of (a[31:0]-b[31:0]).
//   - sraw: sign-extend bit 31 of (a[31:0] >>> b[4:0]).
//  Illegal instructions
//   - Enables are sampled only when in_valid=1.
//   - Enable count !=1 -> illegal=1, out_result=0, no writeback, no forwarding.
//  Loader port and debug read
//   - ld_en writes ld_data to ld_addr at the edge; writes to x0 are ignored.
//   - Same-edge collision with a writeback to the same index: writeback wins.
//   - An exec read of ld_addr in the same cycle sees the old value; ld data is not forwarded.
//   - dbg_data reflects architectural state only, with no forwarding.
// TESTING
//  1 Hold rst_n=0 for 2 cycles, release -> out_valid=0; dbg_data=0 for all 32 indices.
//  2 Load x1=5, x2=7; issue add rd=3 -> next cycle out_result=12, out_valid=1; one cycle later dbg x3=12.
//  3 Issue add x3=x1+x2, then next cycle sub x4=x3-x1 -> forwarded, out_result=7; later x4=7.
//  4 Load x1=-16 (0xFFFF_FFFF_FFFF_FFF0), x2=2.
//    sra -> 0xFFFF_FFFF_FFFF_FFFC; srl -> 0x3FFF_FFFF_FFFF_FFFC.
//    Load x1=0x0000_0000_8000_0000; sraw by 2 -> 0xFFFF_FFFF_E000_0000.
//  5 add_en+or_en both asserted with rd=5 -> illegal=1, out_result=0, x5 unchanged.
//    add with rd=0 -> dbg x0 stays 0.
//  6 Issue add rd=6, assert rst_n=0 in the next cycle -> x6 remains 0, out_valid=0.
//    Load x1=3 and issue slt x7=(x1<x2) with x2=-1 -> x7=0; sltu x7 -> 1.

Source files
------------

// File: rtl/rv_exec_stage_if.sv
// rv_exec_stage_if: decoder-to-execute issue bus plus the execute-stage result bus.
//   master (decoder side): drives in_valid, rs1/rs2/rd addresses and the one-hot
//                          op enables; observes out_valid/out_rd/out_result/illegal.
//   slave (execute stage): the reverse.
interface rv_exec_stage_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            add_en, sub_en, sll_en, slt_en, sltu_en, xor_en;
    logic            srl_en, sra_en, or_en, and_en, subw_en, sraw_en;
    logic            out_valid;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_result;
    logic            illegal;

    modport master (
        output in_valid, rs1_addr, rs2_addr, rd_addr,
               add_en, sub_en, sll_en, slt_en, sltu_en, xor_en,
               srl_en, sra_en, or_en, and_en, subw_en, sraw_en,
        input  out_valid, out_rd, out_result, illegal
    );

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rd_addr,
               add_en, sub_en, sll_en, slt_en, sltu_en, xor_en,
               srl_en, sra_en, or_en, and_en, subw_en, sraw_en,
        output out_valid, out_rd, out_result, illegal
    );
endinterface

// File: rtl/rv_exec_stage.sv
// rv_exec_stage: RV64 R-type execute/writeback stage with a 32-entry register file.
//   clk, rst_n           clock, synchronous active-low reset
//   bus (slave)          issue inputs and registered result outputs
//   ld_en/ld_addr/ld_data  loader write port (register-file initialisation)
//   dbg_addr/dbg_data    combinational architectural register read, x0 reads 0
module rv_exec_stage #(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    rv_exec_stage_if.slave   bus,
    input  logic             ld_en,
    input  logic [4:0]       ld_addr,
    input  logic [XLEN-1:0]  ld_data,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data
);
    localparam int SW = $clog2(XLEN);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("rv_exec_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] rf [32];
    logic [11:0]     en;
    logic            legal;
    logic            fwd;
    logic            wb;
    logic [XLEN-1:0] a, b, res;
    logic [SW-1:0]   sh;
    logic signed [31:0] dw, sw;

    assign en = {bus.sraw_en, bus.subw_en, bus.and_en, bus.or_en, bus.sra_en, bus.srl_en,
                 bus.xor_en, bus.sltu_en, bus.slt_en, bus.sll_en, bus.sub_en, bus.add_en};

    // Word ops do not exist on a 32-bit datapath.
    assign legal = ($countones(en) == 1) && !((XLEN == 32) && (en[10] || en[11]));

    // The result register is both the forwarding source and the writeback source.
    assign fwd = bus.out_valid && !bus.illegal && (bus.out_rd != 5'd0);
    assign wb  = fwd;

    assign a = (bus.rs1_addr == 5'd0) ? '0 :
               (fwd && bus.rs1_addr == bus.out_rd) ? bus.out_result : rf[bus.rs1_addr];
    assign b = (bus.rs2_addr == 5'd0) ? '0 :
               (fwd && bus.rs2_addr == bus.out_rd) ? bus.out_result : rf[bus.rs2_addr];

    assign sh = b[SW-1:0];
    assign dw = a[31:0] - b[31:0];
    assign sw = $signed(a[31:0]) >>> b[4:0];

    always_comb begin
        res = en[0]  ? a + b :
              en[1]  ? a - b :
              en[2]  ? a << sh :
              en[3]  ? XLEN'($signed(a) < $signed(b)) :
              en[4]  ? XLEN'(a < b) :
              en[5]  ? a ^ b :
              en[6]  ? a >> sh :
              en[7]  ? XLEN'($signed(a) >>> sh) :
              en[8]  ? a | b :
              en[9]  ? a & b :
              en[10] ? XLEN'(dw) :
              en[11] ? XLEN'(sw) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_rd     <= '0;
            bus.out_result <= '0;
            bus.illegal    <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out_rd     <= bus.rd_addr;
                bus.out_result <= legal ? res : '0;
                bus.illegal    <= !legal;
            end
            if (ld_en && ld_addr != 5'd0) rf[ld_addr] <= ld_data;
            // Later assignment: writeback wins over a same-index loader write.
            if (wb) rf[bus.out_rd] <= bus.out_result;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
endmodule

// File: tb/tb_rv_exec_stage.sv
// tb_rv_exec_stage: directed stimulus with a result scoreboard for rv_exec_stage.
module tb_rv_exec_stage;
    localparam logic [11:0] ADD = 12'h001, SUB = 12'h002, SLL = 12'h004, SLT = 12'h008;
    localparam logic [11:0] SLTU = 12'h010, XOR = 12'h020, SRL = 12'h040, SRA = 12'h080;
    localparam logic [11:0] OR = 12'h100, AND = 12'h200, SUBW = 12'h400, SRAW = 12'h800;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] result;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [63:0] dbg_data;
    logic [11:0] en = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    rv_exec_stage_if #(.XLEN(64)) bus ();

    assign {bus.sraw_en, bus.subw_en, bus.and_en, bus.or_en, bus.sra_en, bus.srl_en,
            bus.xor_en, bus.sltu_en, bus.slt_en, bus.sll_en, bus.sub_en, bus.add_en} = en;

    rv_exec_stage #(.XLEN(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            exp_t e;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got rd=%0d result=%h illegal=%b, none expected",
                         bus.out_rd, bus.out_result, bus.illegal);
            end else begin
                e = sb.pop_front();
                if ({bus.out_rd, bus.out_result, bus.illegal} !== e) begin
                    n_fail++;
                    $display("FAIL result: got rd=%0d result=%h illegal=%b, want rd=%0d result=%h illegal=%b",
                             bus.out_rd, bus.out_result, bus.illegal, e.rd, e.result, e.ill);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [11:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [63:0] res, input logic ill);
        bus.in_valid = 1'b1;
        bus.rs1_addr = r1;
        bus.rs2_addr = r2;
        bus.rd_addr  = rd;
        en = op;
        sb.push_back({rd, res, ill});
        tick(1);
        bus.in_valid = 1'b0;
        en = '0;
    endtask

    task automatic load(input logic [4:0] addr, input logic [63:0] data);
        ld_en = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick(1);
        ld_en = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] addr, input logic [63:0] want);
        dbg_addr = addr;
        #1;
        n_chk++;
        if (dbg_data !== want) begin
            n_fail++;
            $display("FAIL %s: x%0d got %h want %h", name, addr, dbg_data, want);
        end
    endtask

    task automatic chk_idle(input string name);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: out_valid got %b want 0", name, bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.rd_addr  = '0;
        tick(2);
        rst_n = 1'b1;
        chk_idle("reset_out_valid");
        for (int i = 0; i < 32; i++) chk_reg("reset_reg", 5'(i), 64'd0);

        load(5'd1, 64'd5);
        load(5'd2, 64'd7);
        issue(ADD, 5'd1, 5'd2, 5'd3, 64'd12, 1'b0);
        tick(1);
        chk_reg("add_wb", 5'd3, 64'd12);

        issue(ADD, 5'd1, 5'd2, 5'd3, 64'd12, 1'b0);
        issue(SUB, 5'd3, 5'd1, 5'd4, 64'd7, 1'b0);
        tick(2);
        chk_reg("fwd_sub_wb", 5'd4, 64'd7);

        load(5'd1, 64'hFFFF_FFFF_FFFF_FFF0);
        load(5'd2, 64'd2);
        issue(SRA, 5'd1, 5'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        issue(SRL, 5'd1, 5'd2, 5'd9, 64'h3FFF_FFFF_FFFF_FFFC, 1'b0);
        issue(SLL, 5'd1, 5'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0);
        issue(XOR, 5'd1, 5'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
        issue(OR,  5'd1, 5'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
        issue(AND, 5'd1, 5'd1, 5'd16, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        load(5'd1, 64'h0000_0000_8000_0000);
        issue(SRAW, 5'd1, 5'd2, 5'd10, 64'hFFFF_FFFF_E000_0000, 1'b0);
        issue(SUBW, 5'd1, 5'd2, 5'd17, 64'h0000_0000_7FFF_FFFE, 1'b0);
        issue(SUBW, 5'd2, 5'd1, 5'd18, 64'hFFFF_FFFF_8000_0002, 1'b0);
        tick(2);
        chk_reg("sra_wb", 5'd8, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_reg("sraw_wb", 5'd10, 64'hFFFF_FFFF_E000_0000);

        issue(ADD | OR, 5'd1, 5'd2, 5'd5, 64'd0, 1'b1);
        issue(ADD, 5'd5, 5'd2, 5'd11, 64'd2, 1'b0);
        issue(12'h000, 5'd1, 5'd2, 5'd19, 64'd0, 1'b1);
        issue(ADD, 5'd1, 5'd2, 5'd0, 64'h0000_0000_8000_0002, 1'b0);
        tick(2);
        chk_reg("illegal_no_wb", 5'd5, 64'd0);
        chk_reg("no_op_no_wb", 5'd19, 64'd0);
        chk_reg("x0_stays_zero", 5'd0, 64'd0);
        chk_reg("no_fwd_from_illegal", 5'd11, 64'd2);

        issue(ADD, 5'd2, 5'd2, 5'd12, 64'd4, 1'b0);
        load(5'd12, 64'd99);
        tick(1);
        chk_reg("wb_beats_load", 5'd12, 64'd4);

        issue(ADD, 5'd2, 5'd2, 5'd6, 64'd4, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_idle("reset_flush_out_valid");
        tick(1);
        chk_reg("reset_drops_wb", 5'd6, 64'd0);
        chk_reg("reset_clears_reg", 5'd2, 64'd0);

        load(5'd1, 64'd3);
        load(5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(SLT, 5'd1, 5'd2, 5'd7, 64'd0, 1'b0);
        tick(1);
        chk_reg("slt_wb", 5'd7, 64'd0);
        issue(SLTU, 5'd1, 5'd2, 5'd7, 64'd1, 1'b0);
        tick(1);
        chk_reg("sltu_wb", 5'd7, 64'd1);
        tick(2);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL results_missing: got %0d outstanding want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
